// File: rtl/display_pkg.sv
// Shared constants, FSM state type and the double-dabble nibble adjust for display_scan.
package display_pkg;
    localparam logic [3:0] DIG_MINUS  = 4'b1010;
    localparam int         NUM_DIGITS = 4;
    localparam int         BCD_DIGITS = 5;

    typedef enum logic {IDLE, CONVERT} state_e;

    function automatic logic [BCD_DIGITS*4-1:0] dabble_adjust(input logic [BCD_DIGITS*4-1:0] b);
        logic [BCD_DIGITS*4-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one adjust+shift per cycle after start, done pulses once
// the final shift has landed in bcd.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      done,
    output logic [BCD_DIGITS*4-1:0]   bcd
);
    localparam int BW = BCD_DIGITS * 4;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    bcd_q, bcd_d, adj;
    logic [CW-1:0]    cnt_q;
    logic             active_q, done_q;

    always_comb begin
        adj   = dabble_adjust(bcd_q);
        bcd_d = (adj << 1) | BW'(bin_q[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                bin_q    <= bin;
                bcd_q    <= '0;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                bcd_q <= bcd_d;
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/display_scan.sv
// Sign-magnitude to BCD conversion plus 4-digit multiplexed scan driving seven_seg.
// Define DISPLAY_SCAN_LZB_EN to blank leading zeros.
module display_scan
    import display_pkg::*;
#(
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    input  logic [3:0]       dp_mask,
    output logic             busy,
    output logic             overflow,
    output logic [3:0]       digit,
    output logic             dot,
    output logic [3:0]       an
);
    localparam int RW = $clog2(REFRESH_DIV);

    state_e                          state_q;
    logic                            busy_q, ovf_q, neg_q;
    logic [3:0]                      dp_q;
    logic [NUM_DIGITS-1:0][3:0]      code_q, code_d;
    logic [NUM_DIGITS-1:0]           dpd_q, dp_d, blank_q, blank_d;
    logic                            ovf_d, start, done;
    logic [BCD_DIGITS*4-1:0]         bcd;

    assign start = (state_q == IDLE) && load;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_b2b (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (mag),
        .done  (done),
        .bcd   (bcd)
    );

    // Display contents as they will be committed when the conversion completes.
    always_comb begin
        code_d  = bcd[4*NUM_DIGITS-1:0];
        dp_d    = dp_q;
        blank_d = '0;
        ovf_d   = (bcd[19:16] != 4'd0) || (neg_q && bcd[15:12] != 4'd0);
        if (neg_q) code_d[NUM_DIGITS-1] = DIG_MINUS;
`ifdef DISPLAY_SCAN_LZB_EN
        begin : lzb
            logic seen;
            seen = 1'b0;
            // The sign slot never blanks; digit 0 is never considered.
            for (int i = NUM_DIGITS-1; i >= 1; i--) begin
                if (!(neg_q && i == NUM_DIGITS-1)) begin
                    if (code_d[i] != 4'd0) seen = 1'b1;
                    blank_d[i] = !seen;
                end
            end
        end
`endif
        if (ovf_d) begin
            code_d  = {NUM_DIGITS{DIG_MINUS}};
            dp_d    = '0;
            blank_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            dp_q    <= '0;
            code_q  <= '0;
            dpd_q   <= '0;
            blank_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    neg_q   <= neg;
                    dp_q    <= dp_mask;
                    busy_q  <= 1'b1;
                    state_q <= CONVERT;
                end
                CONVERT: if (done) begin
                    busy_q  <= 1'b0;
                    ovf_q   <= ovf_d;
                    code_q  <= code_d;
                    dpd_q   <= dp_d;
                    blank_q <= blank_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [RW-1:0] rcnt_q;
    logic [1:0]    scan_q, scan_d;
    logic          wrap;
    logic [3:0]    digit_q, an_q;
    logic          dot_q;

    assign wrap   = (rcnt_q == RW'(REFRESH_DIV - 1));
    assign scan_d = wrap ? scan_q + 2'd1 : scan_q;

    // digit/dot follow the new slot; an uses the old slot so it lags by the
    // one cycle seven_seg spends registering the segments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q  <= '0;
            scan_q  <= '0;
            digit_q <= '0;
            dot_q   <= 1'b1;
            an_q    <= 4'b1111;
        end else begin
            rcnt_q  <= wrap ? '0 : rcnt_q + 1'b1;
            scan_q  <= scan_d;
            digit_q <= code_q[scan_d];
            dot_q   <= ~dpd_q[scan_d];
            an_q    <= ~(4'b0001 << scan_q) | blank_q;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign digit    = digit_q;
    assign dot      = dot_q;
    assign an       = an_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboarded random bench for display_scan with a decimal-arithmetic reference model.
module tb_display_scan;
    localparam int WIDTH = 14;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst, load, neg;
    logic [WIDTH-1:0] mag;
    logic [3:0]       dp_mask;
    logic             busy, overflow, dot;
    logic [3:0]       digit, an;

    display_scan #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .mag(mag), .neg(neg), .dp_mask(dp_mask),
        .busy(busy), .overflow(overflow), .digit(digit), .dot(dot), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            ovf;
        logic [3:0]      blank;
        logic [3:0]      dp;
        logic [3:0][3:0] code;
    } disp_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    disp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic disp_t model(input int m, input bit n, input logic [3:0] dpm);
        disp_t r;
        int    p;
`ifdef DISPLAY_SCAN_LZB_EN
        int    msd;
`endif
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r.code[i] = 4'((m / p) % 10);
            p = p * 10;
        end
        if (n) r.code[3] = 4'd10;
        r.dp  = dpm;
        r.ovf = n ? (m > 999) : (m > 9999);
`ifdef DISPLAY_SCAN_LZB_EN
        msd = (m >= 1000) ? 3 : (m >= 100) ? 2 : (m >= 10) ? 1 : 0;
        for (int i = 1; i < 4; i++)
            if (i > msd && !(n && i == 3)) r.blank[i] = 1'b1;
`endif
        if (r.ovf) begin
            r.code  = {4{4'd10}};
            r.dp    = '0;
            r.blank = '0;
        end
        return r;
    endfunction

    // Monitor: slot position is derived from edges since reset release.
    disp_t cur;
    int    n_edges, bcnt;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            n_edges = 0;
            bcnt    = 0;
            cur     = '0;
        end else begin
            int s, sp;
            n_edges++;
            s  = (n_edges / DIV) % 4;
            sp = ((n_edges - 1) / DIV) % 4;
            chk("digit", digit, cur.code[s]);
            chk("dot", dot, 1'(~cur.dp[s]));
            chk("an", an, 4'(~(4'b0001 << sp)) | cur.blank);
            if (busy) bcnt++;
            else if (bcnt > 0) begin
                chk("busy_len", bcnt, WIDTH + 1);
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else cur = sb.pop_front();
                bcnt = 0;
            end
            chk("overflow", overflow, cur.ovf);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic do_load(input int m, input bit n, input logic [3:0] d);
        wait_idle();
        mag = WIDTH'(m); neg = n; dp_mask = d; load = 1'b1;
        sb.push_back(model(m, n, d));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic settle();
        wait_idle();
        repeat (4*DIV + 2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_digit", digit, 0);
        chk("rst_dot", dot, 1);
        chk("rst_an", an, 4'b1111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, r;
        load = 0; mag = '0; neg = 0; dp_mask = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (8*DIV) @(negedge clk);

        do_load(1234, 0, 4'b0100); settle();
        do_load(57, 1, 4'b0000);   settle();
        do_load(16383, 0, 4'hF);   settle();
        do_load(9, 0, 4'h0);       settle();
        do_load(1000, 1, 4'h3);    settle();
        do_load(9, 0, 4'h1);       settle();
        do_load(0, 1, 4'h0);       settle();

        // Loads during busy, including the cycle busy falls, must be dropped.
        do_load(4321, 0, 4'b0001);
        repeat (3) @(negedge clk);
        mag = 5; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (WIDTH - 4) @(negedge clk);
        mag = 5; load = 1'b1;
        @(negedge clk); load = 1'b0;
        settle();

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 3);
            m = (r == 0) ? $urandom_range(0, 9) :
                (r == 1) ? $urandom_range(10, 999) :
                (r == 2) ? $urandom_range(1000, 9999) : $urandom_range(0, 16383);
            do_load(m, 1'($urandom_range(0, 1)), 4'($urandom));
            repeat ($urandom_range(0, 4*DIV + 4)) @(negedge clk);
        end
        settle();

        // Reset mid-conversion wipes everything at once.
        do_load(8765, 0, 4'hA);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1 chk_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (4*DIV + 2) @(negedge clk);
        do_load(42, 0, 4'h2); settle();

        chk("queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan.md
# display_scan

Upstream driver for the `seven_seg` decoder on the calculator's 4-digit display. It accepts a sign-magnitude binary result and converts it to BCD with a sequential double-dabble. It then time-multiplexes the four digits, presenting one 4-bit digit code and dot per scan slot to `seven_seg` and driving the active-low anodes, delayed to line up with the decoder's registered output.

## Interface
- `WIDTH`, 14, magnitude width in bits; internal BCD is 5 digits.
- `REFRESH_DIV`, 100000, clk cycles per scan slot (≥2).
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `load`  in  1  one-cycle strobe; accepted only when `busy`=0
- `mag`  in  WIDTH  magnitude, sampled on an accepted `load`
- `neg`  in  1  sign, sampled with `mag`
- `dp_mask`  in  4  dot enables, bit i = digit i (0 = rightmost), sampled with `mag`
- `busy`  out  1  conversion in progress
- `overflow`  out  1  last conversion out of range
- `digit`  out  4  digit code to `seven_seg` `in`
- `dot`  out  1  to `seven_seg` `dot`; active-low, so 1 = dot off
- `an`  out  4  anode enables, active-low

## Operation
- FSM `IDLE`/`CONVERT`.
  - In `IDLE`, `load`=1 latches `mag`/`neg`/`dp_mask`, clears the shift BCD and enters `CONVERT`.
  - `CONVERT` performs WIDTH shift iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left with the binary MSB entering.
  - After the last shift the FSM returns to `IDLE`.
- Range check at completion:
  - positive: BCD digit 4 ≠0 → overflow.
  - negative: BCD digit 4 or 3 ≠0 → overflow. Digit 3 carries the minus sign, so the negative range is −999..−0.
- Display register (4 codes + dp) is written only at completion, so it updates atomically:
  - normal: digits 0..3 = BCD digits 0..3.
  - negative: digit 3 = 4'b1010 (minus).
  - overflow: all four digits = 4'b1010, dp all off, `overflow`=1.
  - `overflow` clears on the next successful completion.
- `load` while `busy` is ignored, and the latched operands are unchanged.
- Scanner (always runs, independent of the FSM):
  - refresh counter 0..REFRESH_DIV−1; on wrap, `scan_idx` increments 0→1→2→3→0.
  - `digit` = display code[`scan_idx`]; `dot` = ~dp[`scan_idx`].

## Timing
- Reset values:
  - `busy`=0, `overflow`=0, `digit`=0, `dot`=1, `an`=4'b1111.
  - display register = four zero codes, dp=0; `scan_idx`=0, refresh counter 0.
- `load` sampled at edge k:
  - `busy`=1 from edge k through edge k+WIDTH; it falls at edge k+WIDTH+1.
  - The display register and `overflow` update on that same edge.
- A `load` in the cycle `busy` falls is still ignored.
- `rst` low mid-conversion aborts the conversion; the display returns to reset contents.
- `digit`/`dot` are registered and change on the edge where `scan_idx` changes.
- `an` is registered from the one-cycle-delayed `scan_idx`, because `seven_seg` registers its output. `an` therefore changes one cycle after `digit`.
- `an` is one-hot low, except for blanked digits, which are held high.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined → leading-zero blanking. At completion, digits above the most significant nonzero digit are marked blank, with digit 0 never blank. A negative sign always stays on digit 3, so digits 2..1 may blank between the sign and the number. Blank slots keep `an` bit = 1.
- Not defined → all four anodes scan and leading zeros show as "0".

## Structure
- Package `display_pkg`: `DIG_MINUS`=4'b1010, `NUM_DIGITS`=4, `BCD_DIGITS`=5, FSM state enum (`IDLE`, `CONVERT`).
- Sub-module `bin2bcd_seq` holds the double-dabble datapath and iteration counter.
  - inputs: `start`, `bin`
  - outputs: `done` pulse, `bcd[19:0]`
- `display_scan` holds the FSM, range check, display register and scanner.

## Test plan
- Reset, then wait 8·REFRESH_DIV cycles with REFRESH_DIV=4 → `digit`=0 in every slot; `an` cycles 1110,1101,1011,0111, lagging `digit` by one cycle.
- `load` with mag=1234, neg=0, dp_mask=0100 → `busy` high exactly 15 cycles. Slots show 4,3,2,1; `dot`=0 only in slot 2.
- mag=57, neg=1 → slot 3 = 4'b1010, slots 1..0 = 5,7. With `DISPLAY_SCAN_LZB_EN`, slot 2's `an` bit stays 1.
- mag=16383, neg=0, and separately mag=1000, neg=1 → `overflow`=1, all slots 4'b1010. A following load of mag=9 clears `overflow`.
- Pulse a second `load` (mag=5) during `busy` → ignored, and the display shows the first value. Assert `rst` mid-conversion → all outputs return to reset values immediately.
